sm3_msg_pad: RTL and testbench

SM3_MSG_PAD -- requirements
Module: sm3_msg_pad

---
 rtl/sm3_pad_pkg.sv | 47 ++++
 rtl/sm3_pad_byte_ins.sv | 31 +++
 rtl/sm3_msg_pad.sv | 175 +++++++++++++++++
 tb/tb_sm3_msg_pad.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm3_pad_pkg.sv
// ---------------------------------------------------------------------------
// sm3_pad_pkg
// Shared definitions for the SM3 message padder: widths, the padder state
// encoding, the legal valid-byte masks and two small mask helpers.
// ---------------------------------------------------------------------------
package sm3_pad_pkg;

    localparam int SM3_BLK_W     = 512;
    localparam int SM3_WORD_W    = 32;
    localparam int SM3_LEN_W     = 64;
    localparam int SM3_BLK_WORDS = SM3_BLK_W / SM3_WORD_W;

    // Valid-byte masks are contiguous from bit 3 (the first byte of the word).
    localparam logic [3:0] MASK_FULL = 4'b1111;
    localparam logic [3:0] MASK_3B   = 4'b1110;
    localparam logic [3:0] MASK_2B   = 4'b1100;
    localparam logic [3:0] MASK_1B   = 4'b1000;
    localparam logic [3:0] MASK_NONE = 4'b0000;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_PAD = 2'd1,
        ST_OUT = 2'd2
    } pad_state_e;

    function automatic logic mask_is_legal(input logic [3:0] mask);
        logic legal;
        case (mask)
            MASK_FULL, MASK_3B, MASK_2B, MASK_1B, MASK_NONE: legal = 1'b1;
            default:                                         legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Number of message bits carried by a word with the given mask.
    function automatic logic [SM3_LEN_W-1:0] mask_bit_len(input logic [3:0] mask);
        logic [SM3_LEN_W-1:0] bits;
        bits = '0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                bits = bits + 64'd8;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/sm3_pad_byte_ins.sv
// ---------------------------------------------------------------------------
// sm3_pad_byte_ins
// Combinational 0x80 insertion for the last word of a message.
//   word     : last message word, big-endian ([31:24] is the first byte)
//   mask     : legal valid-byte mask of that word
//   padded   : word with 0x80 in the first invalid byte, zeros below it
//   pad_pend : the word is full, so 0x80 must start the next slot instead
// ---------------------------------------------------------------------------
module sm3_pad_byte_ins
    import sm3_pad_pkg::*;
(
    input  logic [SM3_WORD_W-1:0] word,
    input  logic [3:0]            mask,
    output logic [SM3_WORD_W-1:0] padded,
    output logic                  pad_pend
);

    always_comb begin
        padded   = word;
        pad_pend = 1'b0;
        case (mask)
            MASK_FULL: pad_pend = 1'b1;
            MASK_3B:   padded   = {word[31:8], 8'h80};
            MASK_2B:   padded   = {word[31:16], 16'h8000};
            MASK_1B:   padded   = {word[31:24], 24'h80_0000};
            MASK_NONE: padded   = 32'h8000_0000;
            default:   padded   = word;
        endcase
    end

endmodule

// File: rtl/sm3_msg_pad.sv
// ---------------------------------------------------------------------------
// sm3_msg_pad
// SM3 message padder: collects 32-bit big-endian message words into a
// 16-word block buffer, appends 0x80, zero fill and the 64-bit bit length,
// and hands complete 512-bit blocks to the compression core.
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   msg_d/msg_vld_byte/msg_vld/
//   msg_lst/msg_rdy               : message word stream in
//   blk_d/blk_vld/blk_lst/blk_rdy : padded block stream out (word 0 in MSBs)
//   err_o                         : one-cycle pulse when a word is rejected
// ---------------------------------------------------------------------------
module sm3_msg_pad
    import sm3_pad_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [SM3_WORD_W-1:0] msg_d,
    input  logic [3:0]            msg_vld_byte,
    input  logic                  msg_vld,
    input  logic                  msg_lst,
    output logic                  msg_rdy,
    output logic [SM3_BLK_W-1:0]  blk_d,
    output logic                  blk_vld,
    output logic                  blk_lst,
    input  logic                  blk_rdy,
    output logic                  err_o
);

    localparam logic [3:0] LAST_SLOT = 4'd15;

    pad_state_e                                 state;
    logic [3:0]                                 wcnt;
    logic [SM3_LEN_W-1:0]                       bit_cnt;
    logic [0:SM3_BLK_WORDS-1][SM3_WORD_W-1:0]   blk_buf;
    logic                                       lst_pend;
    logic                                       need_extra;
    logic                                       pad_pend;

    logic [SM3_WORD_W-1:0] ins_word;
    logic [SM3_WORD_W-1:0] pad_word;
    logic                  ins_pend;
    logic                  accept;
    logic                  bad_mask;
    logic                  tail_slot;

    sm3_pad_byte_ins u_byte_ins (
        .word     (msg_d),
        .mask     (msg_vld_byte),
        .padded   (ins_word),
        .pad_pend (ins_pend)
    );

    assign accept    = msg_vld & msg_rdy;
    // Non-last words may only be full or empty; anything else is dropped.
    assign bad_mask  = !mask_is_legal(msg_vld_byte) ||
                       (!msg_lst && (msg_vld_byte != MASK_FULL) && (msg_vld_byte != MASK_NONE));
    // Slots 14/15 hold the length, so a 0x80 landing there forces an extra block.
    assign tail_slot = (wcnt[3:1] == 3'b111);

    // need_extra marks a block that is only zero-filled; its length goes in the next one.
    always_comb begin
        pad_word = '0;
        if (pad_pend) begin
            pad_word = 32'h8000_0000;
        end else if (!need_extra && (wcnt == 4'd14)) begin
            pad_word = bit_cnt[63:32];
        end else if (!need_extra && (wcnt == LAST_SLOT)) begin
            pad_word = bit_cnt[31:0];
        end
    end

    assign blk_d   = blk_vld ? blk_buf : '0;
    assign blk_lst = blk_vld & lst_pend;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_ACC;
            wcnt       <= '0;
            bit_cnt    <= '0;
            blk_buf    <= '0;
            lst_pend   <= 1'b0;
            need_extra <= 1'b0;
            pad_pend   <= 1'b0;
            msg_rdy    <= 1'b0;
            blk_vld    <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                ST_ACC: begin
                    msg_rdy <= 1'b1;
                    if (accept) begin
                        if (bad_mask) begin
                            err_o <= 1'b1;
                        end else if (!msg_lst) begin
                            if (msg_vld_byte == MASK_FULL) begin
                                blk_buf[wcnt] <= msg_d;
                                bit_cnt       <= bit_cnt + mask_bit_len(msg_vld_byte);
                                if (wcnt == LAST_SLOT) begin
                                    wcnt     <= '0;
                                    lst_pend <= 1'b0;
                                    blk_vld  <= 1'b1;
                                    msg_rdy  <= 1'b0;
                                    state    <= ST_OUT;
                                end else begin
                                    wcnt <= wcnt + 4'd1;
                                end
                            end
                        end else begin
                            // A full last word defers 0x80 to the next slot via pad_pend.
                            blk_buf[wcnt] <= ins_word;
                            bit_cnt       <= bit_cnt + mask_bit_len(msg_vld_byte);
                            pad_pend      <= ins_pend;
                            msg_rdy       <= 1'b0;
                            if (!ins_pend && tail_slot) begin
                                need_extra <= 1'b1;
                            end
                            if (wcnt == LAST_SLOT) begin
                                wcnt     <= '0;
                                lst_pend <= 1'b0;
                                blk_vld  <= 1'b1;
                                state    <= ST_OUT;
                            end else begin
                                wcnt  <= wcnt + 4'd1;
                                state <= ST_PAD;
                            end
                        end
                    end
                end

                ST_PAD: begin
                    blk_buf[wcnt] <= pad_word;
                    pad_pend      <= 1'b0;
                    if (pad_pend && tail_slot) begin
                        need_extra <= 1'b1;
                    end
                    if (wcnt == LAST_SLOT) begin
                        wcnt     <= '0;
                        lst_pend <= !(need_extra || pad_pend);
                        blk_vld  <= 1'b1;
                        state    <= ST_OUT;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end

                ST_OUT: begin
                    if (blk_rdy) begin
                        blk_vld <= 1'b0;
                        if (lst_pend) begin
                            bit_cnt    <= '0;
                            wcnt       <= '0;
                            lst_pend   <= 1'b0;
                            need_extra <= 1'b0;
                            pad_pend   <= 1'b0;
                            msg_rdy    <= 1'b1;
                            state      <= ST_ACC;
                        end else if (need_extra || pad_pend) begin
                            need_extra <= 1'b0;
                            state      <= ST_PAD;
                        end else begin
                            msg_rdy <= 1'b1;
                            state   <= ST_ACC;
                        end
                    end
                end

                default: begin
                    state <= ST_ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm3_msg_pad.sv
// ---------------------------------------------------------------------------
// tb_sm3_msg_pad
// Scoreboard bench for sm3_msg_pad. Each message is padded by a byte-level
// reference model (append 0x80, zero fill to 56 mod 64, 64-bit length) and
// the expected blocks are queued; an independent monitor pops and compares
// them on every block handshake. Random blk_rdy back-pressure, injected
// empty/illegal words and two mid-operation resets are included.
// ---------------------------------------------------------------------------
module tb_sm3_msg_pad;

    logic         clk_i;
    logic         rst_ni;
    logic [31:0]  msg_d;
    logic [3:0]   msg_vld_byte;
    logic         msg_vld;
    logic         msg_lst;
    logic         msg_rdy;
    logic [511:0] blk_d;
    logic         blk_vld;
    logic         blk_lst;
    logic         blk_rdy;
    logic         err_o;

    int checks   = 0;
    int failures = 0;
    int exp_err  = 0;
    int err_seen = 0;
    int stall_tok = 0;

    logic [511:0] exp_blk_q[$];
    bit           exp_lst_q[$];

    logic [3:0] illegal_masks [11] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                       4'b0110, 4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1101};

    sm3_msg_pad dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .msg_d        (msg_d),
        .msg_vld_byte (msg_vld_byte),
        .msg_vld      (msg_vld),
        .msg_lst      (msg_lst),
        .msg_rdy      (msg_rdy),
        .blk_d        (blk_d),
        .blk_vld      (blk_vld),
        .blk_lst      (blk_lst),
        .blk_rdy      (blk_rdy),
        .err_o        (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic report_fail(input string name, input int got, input int exp);
        checks++;
        failures++;
        $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Byte-level SM3 padding reference.
    function automatic void model_push(input logic [7:0] msg[$]);
        logic [7:0]   p[$];
        logic [63:0]  bitlen;
        logic [511:0] blk;
        int           nblk;
        p      = msg;
        bitlen = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
            exp_blk_q.push_back(blk);
            exp_lst_q.push_back(b == nblk - 1);
        end
    endfunction

    // Invalid lower bytes carry random garbage the DUT must overwrite.
    function automatic logic [31:0] word_from(input logic [7:0] msg[$], input int idx, input int cnt);
        logic [31:0] w;
        w = $urandom;
        for (int k = 0; k < cnt; k++) w[31 - 8*k -: 8] = msg[idx + k];
        return w;
    endfunction

    function automatic logic [3:0] mask_of(input int nbytes);
        logic [3:0] m;
        case (nbytes)
            1:       m = 4'b1000;
            2:       m = 4'b1100;
            3:       m = 4'b1110;
            4:       m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    task automatic apply_word(input logic [31:0] d, input logic [3:0] m, input logic l);
        int budget;
        budget = 0;
        @(negedge clk_i);
        msg_d        = d;
        msg_vld_byte = m;
        msg_lst      = l;
        msg_vld      = 1'b1;
        while (!msg_rdy && budget < 500) begin
            @(negedge clk_i);
            budget++;
        end
        if (!msg_rdy) report_fail("msg_rdy_timeout", budget, 0);
        @(posedge clk_i);
        #1 msg_vld = 1'b0;
    endtask

    task automatic maybe_noise(input bit noisy);
        int kind;
        if (noisy && ($urandom_range(0, 5) == 0)) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                apply_word($urandom, 4'b0000, 1'b0);
            end else if (kind == 1) begin
                apply_word($urandom, mask_of($urandom_range(1, 3)), 1'b0);
                exp_err++;
            end else begin
                apply_word($urandom, illegal_masks[$urandom_range(0, 10)], 1'($urandom_range(0, 1)));
                exp_err++;
            end
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] msg[$], input bit noisy);
        int n, nfull, rem, nonlast;
        bit split;
        n     = msg.size();
        nfull = n / 4;
        rem   = n % 4;
        split = 1'($urandom_range(0, 1));
        model_push(msg);
        if (rem != 0)      nonlast = nfull;
        else if (n == 0)   nonlast = 0;
        else if (split)    nonlast = nfull - 1;
        else               nonlast = nfull;
        for (int w = 0; w < nonlast; w++) begin
            maybe_noise(noisy);
            apply_word(word_from(msg, 4*w, 4), 4'b1111, 1'b0);
        end
        maybe_noise(noisy);
        if (rem != 0)
            apply_word(word_from(msg, 4*nfull, rem), mask_of(rem), 1'b1);
        else if (n > 0 && split)
            apply_word(word_from(msg, 4*(nfull - 1), 4), 4'b1111, 1'b1);
        else
            apply_word($urandom, 4'b0000, 1'b1);
    endtask

    function automatic void make_msg(input int n, output logic [7:0] msg[$]);
        msg = {};
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endfunction

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_blk_q.size() != 0 && budget < 3000) begin
            @(negedge clk_i);
            budget++;
        end
        if (exp_blk_q.size() != 0) begin
            report_fail("drain_timeout", exp_blk_q.size(), 0);
            exp_blk_q.delete();
            exp_lst_q.delete();
        end
    endtask

    task automatic pulse_reset();
        rst_ni = 1'b0;
        #1;
        check_output("blk_vld_in_reset", 512'(blk_vld), 512'(0));
        check_output("msg_rdy_in_reset", 512'(msg_rdy), 512'(0));
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            check_output("no_partial_blk", 512'(blk_vld), 512'(0));
        end
    endtask

    // blk_rdy driver: random back-pressure, plus a 10-valid-cycle stall on request.
    initial begin
        int stall_seen;
        int stall_left;
        stall_seen = 0;
        stall_left = 0;
        blk_rdy    = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (stall_tok != stall_seen) begin
                stall_seen = stall_tok;
                stall_left = 10;
            end
            if (stall_left > 0) begin
                blk_rdy = 1'b0;
                if (blk_vld) stall_left--;
            end else begin
                blk_rdy = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: scoreboard compare on handshake, hold-stability while stalled.
    initial begin
        logic [511:0] held_d;
        logic [511:0] eb;
        logic         held_lst;
        bit           held_vld;
        bit           el;
        bit           rdy_chk;
        held_vld = 1'b0;
        rdy_chk  = 1'b0;
        held_d   = '0;
        held_lst = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                held_vld = 1'b0;
                rdy_chk  = 1'b0;
            end else begin
                if (rdy_chk) begin
                    check_output("rdy_after_final", 512'(msg_rdy), 512'(1));
                    rdy_chk = 1'b0;
                end
                if (err_o) err_seen++;
                if (blk_vld) begin
                    check_output("rdy_low_in_out", 512'(msg_rdy), 512'(0));
                    if (held_vld) begin
                        check_output("hold_blk_d", blk_d, held_d);
                        check_output("hold_blk_lst", 512'(blk_lst), 512'(held_lst));
                    end
                    if (blk_rdy) begin
                        if (exp_blk_q.size() == 0) begin
                            report_fail("unexpected_blk", 1, 0);
                        end else begin
                            eb = exp_blk_q.pop_front();
                            el = exp_lst_q.pop_front();
                            check_output("blk_d", blk_d, eb);
                            check_output("blk_lst", 512'(blk_lst), 512'(el));
                            if (el) rdy_chk = 1'b1;
                        end
                        held_vld = 1'b0;
                    end else begin
                        held_vld = 1'b1;
                        held_d   = blk_d;
                        held_lst = blk_lst;
                    end
                end else begin
                    if (held_vld) report_fail("vld_dropped", 0, 1);
                    held_vld = 1'b0;
                end
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        logic [7:0] msg[$];
        logic [7:0] abc[$];
        int         e0;
        int         budget;
        int         dir_len [10] = '{56, 64, 55, 60, 52, 63, 119, 120, 128, 4};

        abc          = '{8'h61, 8'h62, 8'h63};
        msg_d        = '0;
        msg_vld_byte = '0;
        msg_vld      = 1'b0;
        msg_lst      = 1'b0;
        rst_ni       = 1'b0;

        repeat (3) @(negedge clk_i);
        check_output("rst_blk_vld", 512'(blk_vld), 512'(0));
        check_output("rst_blk_lst", 512'(blk_lst), 512'(0));
        check_output("rst_err_o", 512'(err_o), 512'(0));
        check_output("rst_blk_d", blk_d, 512'(0));
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check_output("rdy_after_release", 512'(msg_rdy), 512'(1));

        // An illegal non-last mask must pulse err_o exactly once and change nothing.
        e0 = err_seen;
        apply_word(32'hdead_beef, 4'b1010, 1'b0);
        exp_err++;
        repeat (3) @(negedge clk_i);
        check_output("err_single_pulse", 512'(err_seen - e0), 512'(1));

        $display("[TB] directed messages");
        apply_stimulus(abc, 1'b0);
        make_msg(0, msg);
        apply_stimulus(msg, 1'b0);
        stall_tok++;
        make_msg(56, msg);
        apply_stimulus(msg, 1'b0);
        foreach (dir_len[i]) begin
            make_msg(dir_len[i], msg);
            apply_stimulus(msg, 1'(i % 2));
        end

        $display("[TB] random messages");
        for (int r = 0; r < 30; r++) begin
            make_msg($urandom_range(0, 200), msg);
            apply_stimulus(msg, 1'b1);
        end
        wait_drain();

        $display("[TB] reset mid-message");
        for (int w = 0; w < 7; w++) apply_word($urandom, 4'b1111, 1'b0);
        pulse_reset();
        apply_stimulus(abc, 1'b0);
        wait_drain();

        $display("[TB] reset while a block is presented");
        stall_tok++;
        for (int w = 0; w < 16; w++) apply_word($urandom, 4'b1111, 1'b0);
        budget = 0;
        while (!blk_vld && budget < 50) begin
            @(negedge clk_i);
            budget++;
        end
        if (!blk_vld) report_fail("blk_vld_timeout", budget, 0);
        repeat (3) @(negedge clk_i);
        pulse_reset();
        apply_stimulus(abc, 1'b0);
        make_msg(61, msg);
        apply_stimulus(msg, 1'b1);
        wait_drain();

        repeat (5) @(negedge clk_i);
        check_output("err_count", 512'(err_seen), 512'(exp_err));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
